lsu_writeback: RTL and testbench

Multi-cycle load/store unit that sits directly upstream of the register file write port. It accepts one memory operation from execute and drives a word-addressed data-memory handshake. For loads, it extracts and sign- or zero-extends the addressed byte, halfword or word and writes it back through a single-cycle register-file write pulse. It also reports misaligned accesses and illegal funct3 encodings.

---
 rtl/lsu_writeback_if.sv | 51 +++++
 rtl/lsu_writeback.sv | 166 ++++++++++++++++
 tb/tb_lsu_writeback.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_writeback_if.sv
// Bundle of the execute-request, data-memory and register-file write signals
// around lsu_writeback. The unit is the slave; the surrounding pipeline and
// memory form the master side.
//
// Handshake rules: an operation moves from execute to the unit on a rising
// edge where req_valid && req_ready. Execute holds req_valid and the request
// fields until then. mem_req is held, with mem_we/mem_addr/mem_wdata/
// mem_wstrb stable, until the memory answers with a single-cycle mem_ack
// (mem_rdata valid in that same cycle). rf_we is a single-cycle qualifier for
// rf_waddr/rf_wdata.
interface lsu_writeback_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
);
    logic              req_valid;
    logic              req_ready;
    logic              req_is_load;
    logic [2:0]        req_funct3;
    logic [XLEN-1:0]   req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic [REG_AW-1:0] req_rd;

    logic              mem_req;
    logic              mem_we;
    logic [XLEN-1:0]   mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic [3:0]        mem_wstrb;
    logic              mem_ack;
    logic [XLEN-1:0]   mem_rdata;

    logic              rf_we;
    logic [REG_AW-1:0] rf_waddr;
    logic [XLEN-1:0]   rf_wdata;

    logic              exc_misalign;
    logic              busy;

    modport slave (
        input  req_valid, req_is_load, req_funct3, req_addr, req_wdata, req_rd,
        input  mem_ack, mem_rdata,
        output req_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output rf_we, rf_waddr, rf_wdata, exc_misalign, busy
    );

    modport master (
        output req_valid, req_is_load, req_funct3, req_addr, req_wdata, req_rd,
        output mem_ack, mem_rdata,
        input  req_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  rf_we, rf_waddr, rf_wdata, exc_misalign, busy
    );
endinterface

// File: rtl/lsu_writeback.sv
// Multi-cycle load/store unit feeding the register-file write port.
// One operation at a time: IDLE accepts, ACCESS runs the memory handshake,
// WB issues the single register-file write pulse for loads.
module lsu_writeback #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic               clk,
    input  logic               rst,
    lsu_writeback_if.slave     bus,
    output logic [1:0]         state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WB     = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Captured request fields used after acceptance.
    logic [1:0]        addr_lo_q;
    logic [2:0]        funct3_q;
    logic [REG_AW-1:0] rd_q;
    logic              is_load_q;

    logic              accept;
    logic              f3_ok;
    logic              aligned;
    logic              req_legal;
    logic [XLEN-1:0]   st_wdata;
    logic [3:0]        st_wstrb;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [XLEN-1:0]   ld_data;

    assign accept    = (state == IDLE) && bus.req_valid;
    assign state_dbg = state;

    // Classify the incoming request: funct3 legality and natural alignment.
    always_comb begin
        f3_ok   = 1'b0;
        aligned = 1'b1;
        case (bus.req_funct3)
            3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
            3'b100, 3'b101:         f3_ok = bus.req_is_load;
            default:                f3_ok = 1'b0;
        endcase
        case (bus.req_funct3[1:0])
            2'b01:   aligned = ~bus.req_addr[0];
            2'b10:   aligned = (bus.req_addr[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
        req_legal = f3_ok && aligned;
    end

    // Store lane formatting: replicate the datum across lanes, strobe the target.
    always_comb begin
        st_wdata = bus.req_wdata;
        st_wstrb = 4'b1111;
        case (bus.req_funct3[1:0])
            2'b00: begin
                st_wdata = {4{bus.req_wdata[7:0]}};
                st_wstrb = 4'b0001 << bus.req_addr[1:0];
            end
            2'b01: begin
                st_wdata = {2{bus.req_wdata[15:0]}};
                st_wstrb = bus.req_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_wdata = bus.req_wdata;
                st_wstrb = 4'b1111;
            end
        endcase
    end

    // Load extraction: select the addressed lane, then sign/zero extend.
    always_comb begin
        ld_byte = 8'h00;
        case (addr_lo_q)
            2'b00:   ld_byte = bus.mem_rdata[7:0];
            2'b01:   ld_byte = bus.mem_rdata[15:8];
            2'b10:   ld_byte = bus.mem_rdata[23:16];
            default: ld_byte = bus.mem_rdata[31:24];
        endcase
        ld_half = addr_lo_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        case (funct3_q)
            3'b000:  ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'b100:  ld_data = {{(XLEN-8){1'b0}}, ld_byte};
            3'b001:  ld_data = {{(XLEN-16){ld_half[15]}}, ld_half};
            3'b101:  ld_data = {{(XLEN-16){1'b0}}, ld_half};
            default: ld_data = bus.mem_rdata;
        endcase
    end

    // State register; reset aborts any in-flight access immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state and state-decoded handshake outputs.
    always_comb begin
        state_next     = state;
        bus.req_ready  = 1'b0;
        bus.mem_req    = 1'b0;
        bus.busy       = 1'b1;
        bus.rf_we      = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                bus.busy      = 1'b0;
                if (accept && req_legal) state_next = ACCESS;
            end
            ACCESS: begin
                bus.mem_req = 1'b1;
                if (bus.mem_ack) state_next = is_load_q ? WB : IDLE;
            end
            WB: begin
                bus.rf_we  = (rd_q != '0);
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Request capture, memory-side registers and load result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_lo_q     <= 2'b00;
            funct3_q      <= 3'b000;
            rd_q          <= '0;
            is_load_q     <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_wstrb <= 4'b0000;
            bus.rf_waddr  <= '0;
            bus.rf_wdata  <= '0;
        end else begin
            if (accept && req_legal) begin
                addr_lo_q     <= bus.req_addr[1:0];
                funct3_q      <= bus.req_funct3;
                rd_q          <= bus.req_rd;
                is_load_q     <= bus.req_is_load;
                bus.mem_we    <= ~bus.req_is_load;
                bus.mem_addr  <= {bus.req_addr[XLEN-1:2], 2'b00};
                bus.mem_wdata <= bus.req_is_load ? '0 : st_wdata;
                bus.mem_wstrb <= bus.req_is_load ? 4'b0000 : st_wstrb;
            end
            if ((state == ACCESS) && bus.mem_ack && is_load_q) begin
                bus.rf_waddr <= rd_q;
                bus.rf_wdata <= ld_data;
            end
        end
    end

    // Rejected requests raise a one-cycle exception pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) bus.exc_misalign <= 1'b0;
        else     bus.exc_misalign <= accept && !req_legal;
    end

endmodule

// File: tb/tb_lsu_writeback.sv
module tb_lsu_writeback;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] state_dbg;

    int checks = 0;
    int errors = 0;

    lsu_writeback_if #(.XLEN(32), .REG_AW(5)) bus ();

    lsu_writeback #(.XLEN(32), .REG_AW(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- expected state (model) ----------------
    bit          cmp_en    = 1'b0;
    bit          exp_ready = 1'b1;
    bit          exp_busy  = 1'b0;
    bit          exp_mreq  = 1'b0;
    bit          exp_we    = 1'b0;
    bit          exp_exc   = 1'b0;
    bit          exp_rfwe  = 1'b0;
    logic [31:0] exp_addr  = '0;
    logic [31:0] exp_wdata = '0;
    logic [3:0]  exp_strb  = '0;
    logic [36:0] exp_q[$];  // {waddr, wdata} of register writes still due

    logic [31:0] cap_wdata;
    logic [3:0]  cap_strb;
    logic [31:0] cap_rf_wdata;
    logic [4:0]  cap_rf_waddr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Model: request legality from RV32I rules and natural alignment.
    function automatic bit model_legal(input bit ld, input logic [2:0] f3, input logic [31:0] a);
        bit f3_ok;
        int size;
        if (ld) f3_ok = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
        else    f3_ok = (f3 == 0) || (f3 == 1) || (f3 == 2);
        size = 1 << f3[1:0];
        return f3_ok && ((a % size) == 0);
    endfunction

    // Model: load result via shift/mask arithmetic on the read word.
    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] w);
        int          size;
        int          off;
        logic [31:0] v;
        size = 1 << f3[1:0];
        off  = (size == 4) ? 0 : (a % 4) - ((a % 4) % size);
        v    = w >> (8 * off);
        if (size == 1) begin
            v = v & 32'hFF;
            if (!f3[2] && v >= 32'h80) v = v + 32'hFFFF_FF00;
        end else if (size == 2) begin
            v = v & 32'hFFFF;
            if (!f3[2] && v >= 32'h8000) v = v + 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic logic [31:0] model_st_data(input logic [2:0] f3, input logic [31:0] d);
        if (f3[1:0] == 2'b00) return (d & 32'hFF) * 32'h0101_0101;
        if (f3[1:0] == 2'b01) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [3:0] model_st_strb(input logic [2:0] f3, input logic [31:0] a);
        int lane;
        lane = a % 4;
        if (f3[1:0] == 2'b00) return 4'(1 << lane);
        if (f3[1:0] == 2'b01) return 4'(3 << (lane - (lane % 2)));
        return 4'hF;
    endfunction

    task automatic set_idle();
        exp_ready = 1'b1;
        exp_busy  = 1'b0;
        exp_mreq  = 1'b0;
        exp_exc   = 1'b0;
        exp_rfwe  = 1'b0;
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (cmp_en && !rst) begin
            chk("req_ready", bus.req_ready, exp_ready);
            chk("busy", bus.busy, exp_busy);
            chk("busy_vs_state", (state_dbg != 2'd0), exp_busy);
            chk("mem_req", bus.mem_req, exp_mreq);
            chk("exc_misalign", bus.exc_misalign, exp_exc);
            chk("rf_we", bus.rf_we, exp_rfwe);
            if (exp_mreq) begin
                chk("mem_we", bus.mem_we, exp_we);
                chk("mem_addr", bus.mem_addr, exp_addr);
                if (exp_we) begin
                    chk("mem_wdata", bus.mem_wdata, exp_wdata);
                    chk("mem_wstrb", bus.mem_wstrb, exp_strb);
                end
            end
            if (bus.rf_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("rf_unexpected_write", 32'(bus.rf_waddr), 32'hFFFF_FFFF);
                end else begin
                    logic [36:0] e;
                    e = exp_q.pop_front();
                    chk("rf_waddr", 32'(bus.rf_waddr), 32'(e[36:32]));
                    chk("rf_wdata", bus.rf_wdata, e[31:0]);
                end
            end
        end
    end

    // ---------------- driver ----------------
    // Called #1 after a rising edge with the unit idle; returns the same way.
    task automatic do_op(input bit ld, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [4:0] rd, input int waits,
                         input logic [31:0] rdata);
        bit legal;
        legal           = model_legal(ld, f3, addr);
        bus.req_valid   = 1'b1;
        bus.req_is_load = ld;
        bus.req_funct3  = f3;
        bus.req_addr    = addr;
        bus.req_wdata   = wd;
        bus.req_rd      = rd;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        if (!legal) begin
            set_idle();
            exp_exc = 1'b1;
            @(posedge clk); #1;
            exp_exc = 1'b0;
            return;
        end
        exp_ready = 1'b0;
        exp_busy  = 1'b1;
        exp_mreq  = 1'b1;
        exp_we    = !ld;
        exp_addr  = addr & 32'hFFFF_FFFC;
        exp_wdata = model_st_data(f3, wd);
        exp_strb  = model_st_strb(f3, addr);
        cap_wdata = bus.mem_wdata;
        cap_strb  = bus.mem_wstrb;
        for (int w = 0; w <= waits; w++) begin
            bus.mem_ack   = (w == waits);
            bus.mem_rdata = (w == waits) ? rdata : 32'h5A5A_5A5A;
            @(posedge clk); #1;
        end
        bus.mem_ack = 1'b0;
        exp_mreq    = 1'b0;
        if (ld) begin
            exp_rfwe = (rd != 0);
            if (rd != 0) exp_q.push_back({rd, model_load(f3, addr, rdata)});
            cap_rf_wdata = bus.rf_wdata;
            cap_rf_waddr = bus.rf_waddr;
            @(posedge clk); #1;
            exp_rfwe = 1'b0;
        end
        exp_busy  = 1'b0;
        exp_ready = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.req_valid   = 1'b0;
        bus.req_is_load = 1'b0;
        bus.req_funct3  = 3'b000;
        bus.req_addr    = '0;
        bus.req_wdata   = '0;
        bus.req_rd      = '0;
        bus.mem_ack     = 1'b0;
        bus.mem_rdata   = '0;
        set_idle();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("reset_req_ready", bus.req_ready, 1);
        chk("reset_busy", bus.busy, 0);
        chk("reset_mem_req", bus.mem_req, 0);
        chk("reset_mem_addr", bus.mem_addr, 0);
        chk("reset_mem_wstrb", 32'(bus.mem_wstrb), 0);
        chk("reset_rf_we", bus.rf_we, 0);
        chk("reset_rf_wdata", bus.rf_wdata, 0);
        chk("reset_exc", bus.exc_misalign, 0);
        cmp_en = 1'b1;

        // SW then LW of the same word.
        do_op(0, 3'b010, 32'h100, 32'hDEAD_BEEF, 5'd0, 0, 32'h0);
        chk("sw_strb", 32'(cap_strb), 32'hF);
        chk("sw_wdata", cap_wdata, 32'hDEAD_BEEF);
        do_op(1, 3'b010, 32'h100, 32'h0, 5'd5, 0, 32'hDEAD_BEEF);
        chk("lw_wdata", cap_rf_wdata, 32'hDEAD_BEEF);
        chk("lw_waddr", 32'(cap_rf_waddr), 32'd5);

        // Sub-word stores.
        do_op(0, 3'b000, 32'h103, 32'h0000_00A5, 5'd0, 0, 32'h0);
        chk("sb_strb", 32'(cap_strb), 32'h8);
        chk("sb_wdata", cap_wdata, 32'hA5A5_A5A5);
        do_op(0, 3'b001, 32'h102, 32'h0000_1234, 5'd0, 0, 32'h0);
        chk("sh_strb", 32'(cap_strb), 32'hC);
        chk("sh_wdata", cap_wdata, 32'h1234_1234);
        do_op(0, 3'b000, 32'h101, 32'hFFFF_FF3C, 5'd0, 1, 32'h0);
        chk("sb1_strb", 32'(cap_strb), 32'h2);
        do_op(0, 3'b001, 32'h200, 32'hABCD_5678, 5'd0, 0, 32'h0);
        chk("sh0_strb", 32'(cap_strb), 32'h3);
        chk("sh0_wdata", cap_wdata, 32'h5678_5678);

        // Load extraction from 0x80FF7F01.
        do_op(1, 3'b000, 32'h3, 32'h0, 5'd1, 0, 32'h80FF_7F01);
        chk("lb3", cap_rf_wdata, 32'hFFFF_FF80);
        do_op(1, 3'b100, 32'h3, 32'h0, 5'd2, 0, 32'h80FF_7F01);
        chk("lbu3", cap_rf_wdata, 32'h0000_0080);
        do_op(1, 3'b001, 32'h2, 32'h0, 5'd3, 0, 32'h80FF_7F01);
        chk("lh2", cap_rf_wdata, 32'hFFFF_80FF);
        do_op(1, 3'b101, 32'h0, 32'h0, 5'd4, 1, 32'h80FF_7F01);
        chk("lhu0", cap_rf_wdata, 32'h0000_7F01);
        do_op(1, 3'b000, 32'h1, 32'h0, 5'd6, 0, 32'h80FF_7F01);
        chk("lb1", cap_rf_wdata, 32'h0000_007F);
        do_op(1, 3'b100, 32'h2, 32'h0, 5'd7, 0, 32'h80FF_7F01);
        chk("lbu2", cap_rf_wdata, 32'h0000_00FF);
        do_op(1, 3'b000, 32'h0, 32'h0, 5'd31, 0, 32'h80FF_7F01);
        chk("lb0", cap_rf_wdata, 32'h0000_0001);

        // Rejected requests.
        do_op(1, 3'b010, 32'h102, 32'h0, 5'd8, 0, 32'h0);
        do_op(1, 3'b001, 32'h101, 32'h0, 5'd8, 0, 32'h0);
        do_op(1, 3'b011, 32'h100, 32'h0, 5'd8, 0, 32'h0);
        do_op(0, 3'b100, 32'h100, 32'h0, 5'd0, 0, 32'h0);
        do_op(0, 3'b010, 32'h101, 32'h0, 5'd0, 0, 32'h0);
        do_op(0, 3'b001, 32'h103, 32'h0, 5'd0, 0, 32'h0);

        // Wait states and rd = 0.
        do_op(0, 3'b010, 32'h204, 32'h1122_3344, 5'd0, 3, 32'h0);
        do_op(1, 3'b010, 32'h208, 32'h0, 5'd0, 2, 32'hCAFE_F00D);
        do_op(1, 3'b001, 32'h20A, 32'h0, 5'd9, 3, 32'h8001_0002);
        chk("lh_wait", cap_rf_wdata, 32'hFFFF_8001);

        // Reset while a load waits for its ack.
        bus.req_valid   = 1'b1;
        bus.req_is_load = 1'b1;
        bus.req_funct3  = 3'b010;
        bus.req_addr    = 32'h40;
        bus.req_rd      = 5'd7;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        exp_ready = 1'b0;
        exp_busy  = 1'b1;
        exp_mreq  = 1'b1;
        exp_we    = 1'b0;
        exp_addr  = 32'h40;
        @(negedge clk); #2;
        set_idle();
        rst = 1'b1;
        #1;
        chk("abort_mem_req", bus.mem_req, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_rf_we", bus.rf_we, 0);
        @(posedge clk); #1;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h1234_5678;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
        @(posedge clk); #1;

        // Normal operation afterwards.
        do_op(1, 3'b101, 32'h42, 32'h0, 5'd10, 0, 32'hBEEF_1234);
        chk("post_reset_lhu", cap_rf_wdata, 32'h0000_BEEF);
        do_op(0, 3'b000, 32'h42, 32'h0000_0011, 5'd0, 0, 32'h0);
        chk("post_reset_sb_strb", 32'(cap_strb), 32'h4);
        repeat (2) @(posedge clk);
        #1;
        chk("rf_writes_outstanding", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Bound the whole run.
    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
